// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-side PC sequencer: FSM state encoding,
// next-PC source codes and default vector addresses.
package pc_sequencer_pkg;

   // Sequencer states (3-bit encoding).
   typedef enum logic [2:0] {
      S_RESET = 3'd0,
      S_RUN   = 3'd1,
      S_IMM   = 3'd2,
      S_DRAIN = 3'd3,
      S_IVEC  = 3'd4
   } state_e;

   // Which source the next-PC mux picked this cycle.
   //   SEL_HOLD  : pc unchanged (draining, redirect during drain, idle)
   //   SEL_STALL : pc unchanged because decode has a load-use hazard
   //   SEL_INC   : sequential pc+1
   //   SEL_RET   : popped return address
   //   SEL_BR    : branch target
   //   SEL_WORD  : vector contents read from imem
   //   SEL_IVEC  : interrupt vector slot address
   //   SEL_IRQ   : pc unchanged, interrupt entry begins
   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,
      SEL_STALL = 3'd1,
      SEL_INC   = 3'd2,
      SEL_RET   = 3'd3,
      SEL_BR    = 3'd4,
      SEL_WORD  = 3'd5,
      SEL_IVEC  = 3'd6,
      SEL_IRQ   = 3'd7
   } pc_sel_e;

   localparam int unsigned RST_VEC_DEFAULT = 0;
   localparam int unsigned INT_VEC_DEFAULT = 1;

endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// Combinational priority selector for the next program counter.
// Reports the chosen source so the sequencer FSM can follow the same decision.
module pc_next_mux
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned WORD_WIDTH   = 16,
   parameter int unsigned INT_VEC_ADDR = INT_VEC_DEFAULT
) (
   input  state_e                state,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic [WORD_WIDTH-1:0] imem_word,
   input  logic                  ret_valid,
   input  logic [PC_WIDTH-1:0]   ret_pc,
   input  logic                  br_taken,
   input  logic [PC_WIDTH-1:0]   br_target,
   input  logic                  load_use,
   input  logic                  int_req,
   input  logic                  pipe_empty,
   output pc_sel_e               sel,
   output logic [PC_WIDTH-1:0]   pc_next
);

   // Pick the PC source by state; ret beats branch beats stall beats interrupt.
   always_comb begin
      sel = SEL_HOLD;
      case (state)
         S_RESET: sel = SEL_WORD;
         S_RUN: begin
            if (ret_valid)     sel = SEL_RET;
            else if (br_taken) sel = SEL_BR;
            else if (load_use) sel = SEL_STALL;
            else if (int_req)  sel = SEL_IRQ;
            else               sel = SEL_INC;
         end
         S_IMM: begin
            // No interrupt check here: the immediate must stay with its opcode.
            if (ret_valid)     sel = SEL_RET;
            else if (br_taken) sel = SEL_BR;
            else if (load_use) sel = SEL_STALL;
            else               sel = SEL_INC;
         end
         S_DRAIN: begin
            // A redirect while draining only retargets the saved return PC.
            if (ret_valid || br_taken) sel = SEL_HOLD;
            else if (pipe_empty)       sel = SEL_IVEC;
            else                       sel = SEL_HOLD;
         end
         S_IVEC:  sel = SEL_WORD;
         default: sel = SEL_HOLD;
      endcase
   end

   // Turn the selected source into the PC value (pc+1 wraps naturally).
   always_comb begin
      pc_next = pc;
      case (sel)
         SEL_INC:  pc_next = pc + PC_WIDTH'(1);
         SEL_RET:  pc_next = ret_pc;
         SEL_BR:   pc_next = br_target;
         SEL_WORD: pc_next = PC_WIDTH'(imem_word);
         SEL_IVEC: pc_next = PC_WIDTH'(INT_VEC_ADDR);
         default:  pc_next = pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns pc and the saved interrupt return PC, tags each
// fetched word as instruction or immediate, and drives stall/flush of the
// fetch and decode buffers. Current FSM state is visible on dbg_state.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned WORD_WIDTH   = 16,
   parameter int unsigned RST_VEC_ADDR = RST_VEC_DEFAULT,
   parameter int unsigned INT_VEC_ADDR = INT_VEC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] imem_word,
   input  logic                  fetch_two_word,
   input  logic                  load_use,
   input  logic                  br_taken,
   input  logic [PC_WIDTH-1:0]   br_target,
   input  logic                  ret_valid,
   input  logic [PC_WIDTH-1:0]   ret_pc,
   input  logic                  int_req,
   input  logic                  pipe_empty,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  fetch_valid,
   output logic                  imm_valid,
   output logic                  stall,
   output logic                  flush_fd,
   output logic                  flush_de,
   output logic                  int_ack,
   output logic [PC_WIDTH-1:0]   int_ret_pc,
   output logic [2:0]            dbg_state
);

   state_e                state;
   pc_sel_e               sel;
   logic [PC_WIDTH-1:0]   pc_next;
   logic [PC_WIDTH-1:0]   saved_pc;

   pc_next_mux #(
      .PC_WIDTH     (PC_WIDTH),
      .WORD_WIDTH   (WORD_WIDTH),
      .INT_VEC_ADDR (INT_VEC_ADDR)
   ) u_pc_next_mux (
      .state      (state),
      .pc         (pc),
      .imem_word  (imem_word),
      .ret_valid  (ret_valid),
      .ret_pc     (ret_pc),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .load_use   (load_use),
      .int_req    (int_req),
      .pipe_empty (pipe_empty),
      .sel        (sel),
      .pc_next    (pc_next)
   );

   // Sequencer FSM with the pc and saved_pc registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_RESET;
         pc       <= PC_WIDTH'(RST_VEC_ADDR);
         saved_pc <= '0;
      end else begin
         pc <= pc_next;
         case (state)
            S_RESET: state <= S_RUN;
            S_RUN: begin
               if (sel == SEL_IRQ) begin
                  saved_pc <= pc;
                  state    <= S_DRAIN;
               end else if (sel == SEL_INC && fetch_two_word) begin
                  state <= S_IMM;
               end
            end
            S_IMM: begin
               if (sel != SEL_STALL) state <= S_RUN;
            end
            S_DRAIN: begin
               if (ret_valid)     saved_pc <= ret_pc;
               else if (br_taken) saved_pc <= br_target;
               if (sel == SEL_IVEC) state <= S_IVEC;
            end
            S_IVEC:  state <= S_RUN;
            default: state <= S_RESET;
         endcase
      end
   end

   // Decode word tags, stall, flush and interrupt handshake from state and selection.
   always_comb begin
      fetch_valid = 1'b0;
      imm_valid   = 1'b0;
      stall       = (sel == SEL_STALL);
      flush_fd    = 1'b0;
      flush_de    = 1'b0;
      int_ack     = (state == S_IVEC);
      int_ret_pc  = (state == S_IVEC) ? saved_pc : '0;
      if (state == S_RUN)
         fetch_valid = (sel == SEL_INC) || (sel == SEL_STALL);
      if (state == S_IMM)
         imm_valid = (sel == SEL_INC) || (sel == SEL_STALL);
      if ((state == S_RUN || state == S_IMM || state == S_DRAIN) &&
          (ret_valid || br_taken)) begin
         flush_fd = 1'b1;
         flush_de = 1'b1;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of the fetch-side PC sequencer.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] imem_word;
   logic        fetch_two_word;
   logic        load_use;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ret_valid;
   logic [31:0] ret_pc;
   logic        int_req;
   logic        pipe_empty;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        imm_valid;
   logic        stall;
   logic        flush_fd;
   logic        flush_de;
   logic        int_ack;
   logic [31:0] int_ret_pc;
   logic [2:0]  dbg_state;

   logic [15:0] mem [0:255];
   logic [68:0] exp_q [$];
   int          total;
   int          bad;
   int          cyc;

   pc_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .imem_word      (imem_word),
      .fetch_two_word (fetch_two_word),
      .load_use       (load_use),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .ret_valid      (ret_valid),
      .ret_pc         (ret_pc),
      .int_req        (int_req),
      .pipe_empty     (pipe_empty),
      .pc             (pc),
      .fetch_valid    (fetch_valid),
      .imm_valid      (imm_valid),
      .stall          (stall),
      .flush_fd       (flush_fd),
      .flush_de       (flush_de),
      .int_ack        (int_ack),
      .int_ret_pc     (int_ret_pc),
      .dbg_state      (dbg_state)
   );

   // clock / imem model
   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign imem_word = mem[pc[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic idle();
      fetch_two_word = 1'b0;
      load_use       = 1'b0;
      br_taken       = 1'b0;
      br_target      = '0;
      ret_valid      = 1'b0;
      ret_pc         = '0;
      int_req        = 1'b0;
      pipe_empty     = 1'b0;
   endtask

   // Expected outputs for the cycle whose inputs were just driven; compared
   // mid-cycle, then advance past the next rising edge.
   task automatic step(input logic [31:0] e_pc, input logic e_fv, input logic e_iv,
                       input logic e_st, input logic e_fl, input logic e_ack,
                       input logic [31:0] e_rpc);
      logic [68:0] e;
      exp_q.push_back({e_pc, e_fv, e_iv, e_st, e_fl, e_ack, e_rpc});
      #2;
      e = exp_q.pop_front();
      check("pc",          pc,                 e[68:37]);
      check("fetch_valid", 32'(fetch_valid),   32'(e[36]));
      check("imm_valid",   32'(imm_valid),     32'(e[35]));
      check("stall",       32'(stall),         32'(e[34]));
      check("flush_fd",    32'(flush_fd),      32'(e[33]));
      check("flush_de",    32'(flush_de),      32'(e[33]));
      check("int_ack",     32'(int_ack),       32'(e[32]));
      check("int_ret_pc",  int_ret_pc,         e[31:0]);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] epc;
   int          r;

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'h0020;
      mem[1] = 16'h0100;
      idle();
      rst = 1'b0;
      #1 rst = 1'b1;

      // reset: everything quiet, pc at the reset vector slot
      step(32'h0, 0, 0, 0, 0, 0, 32'h0);
      step(32'h0, 0, 0, 0, 0, 0, 32'h0);
      check("state_reset", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      // vector fetch, then LDM at 0x20
      step(32'h00, 0, 0, 0, 0, 0, 32'h0);
      fetch_two_word = 1'b1;
      step(32'h20, 1, 0, 0, 0, 0, 32'h0);
      idle();
      step(32'h21, 0, 1, 0, 0, 0, 32'h0);
      step(32'h22, 1, 0, 0, 0, 0, 32'h0);

      // one-cycle load-use stall at 0x23
      load_use = 1'b1;
      step(32'h23, 1, 0, 1, 0, 0, 32'h0);
      idle();
      step(32'h23, 1, 0, 0, 0, 0, 32'h0);

      // branch wins over load-use
      br_taken = 1'b1; br_target = 32'h40; load_use = 1'b1;
      step(32'h24, 0, 0, 0, 1, 0, 32'h0);
      idle();
      fetch_two_word = 1'b1;
      step(32'h40, 1, 0, 0, 0, 0, 32'h0);
      idle();

      // stall while the immediate is presented
      load_use = 1'b1;
      step(32'h41, 0, 1, 1, 0, 0, 32'h0);
      idle();
      step(32'h41, 0, 1, 0, 0, 0, 32'h0);
      fetch_two_word = 1'b1;
      step(32'h42, 1, 0, 0, 0, 0, 32'h0);
      idle();

      // return redirect drops the pending immediate
      ret_valid = 1'b1; ret_pc = 32'h30;
      step(32'h43, 0, 0, 0, 1, 0, 32'h0);
      idle();

      // interrupt at 0x30 with three drain cycles
      int_req = 1'b1;
      step(32'h30, 0, 0, 0, 0, 0, 32'h0);
      step(32'h30, 0, 0, 0, 0, 0, 32'h0);
      step(32'h30, 0, 0, 0, 0, 0, 32'h0);
      pipe_empty = 1'b1;
      step(32'h30, 0, 0, 0, 0, 0, 32'h0);
      idle();
      step(32'h01, 0, 0, 0, 0, 1, 32'h30);
      step(32'h100, 1, 0, 0, 0, 0, 32'h0);

      // hmm: second interrupt, ret (priority over branch) during drain
      int_req = 1'b1;
      step(32'h101, 0, 0, 0, 0, 0, 32'h0);
      ret_valid = 1'b1; ret_pc = 32'h55; br_taken = 1'b1; br_target = 32'h77;
      pipe_empty = 1'b1;
      step(32'h101, 0, 0, 0, 1, 0, 32'h0);
      ret_valid = 1'b0; br_taken = 1'b0;
      step(32'h101, 0, 0, 0, 0, 0, 32'h0);
      idle();
      step(32'h01, 0, 0, 0, 0, 1, 32'h55);

      // pc+1 wraps to zero
      br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
      step(32'h100, 0, 0, 0, 1, 0, 32'h0);
      idle();
      step(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 32'h0);
      step(32'h0, 1, 0, 0, 0, 0, 32'h0);
      step(32'h1, 1, 0, 0, 0, 0, 32'h0);

      // reset pulse while draining abandons the interrupt
      int_req = 1'b1;
      step(32'h2, 0, 0, 0, 0, 0, 32'h0);
      step(32'h2, 0, 0, 0, 0, 0, 32'h0);
      rst = 1'b1;
      step(32'h0, 0, 0, 0, 0, 0, 32'h0);
      pipe_empty = 1'b1;
      step(32'h0, 0, 0, 0, 0, 0, 32'h0);
      rst = 1'b0;
      idle();
      step(32'h0, 0, 0, 0, 0, 0, 32'h0);
      step(32'h20, 1, 0, 0, 0, 0, 32'h0);

      // randomized run: stalls, branches, returns
      epc = 32'h21;
      for (int i = 0; i < 300; i++) begin
         idle();
         r = $urandom_range(0, 9);
         if (r == 0) begin
            ret_valid = 1'b1; ret_pc = $urandom;
            br_taken  = 1'($urandom_range(0, 1)); br_target = $urandom;
            load_use  = 1'($urandom_range(0, 1));
            step(epc, 0, 0, 0, 1, 0, 32'h0);
            epc = ret_pc;
         end else if (r == 1) begin
            br_taken = 1'b1; br_target = $urandom;
            load_use = 1'($urandom_range(0, 1));
            step(epc, 0, 0, 0, 1, 0, 32'h0);
            epc = br_target;
         end else if (r <= 4) begin
            load_use = 1'b1;
            step(epc, 1, 0, 1, 0, 0, 32'h0);
         end else begin
            step(epc, 1, 0, 0, 0, 0, 32'h0);
            epc = epc + 32'd1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
